// File: rtl/pipe_execute.sv
// Y86-64 execute stage: width-generic ALU, condition evaluation, condition-code
// register and a valid/ready output pipeline register with bubble insertion.
module pipe_execute #(
   parameter int         WIDTH = 64,
   parameter logic [3:0] RNONE = 4'hF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_icode,
   input  logic [3:0]       in_ifun,
   input  logic [WIDTH-1:0] in_valC,
   input  logic [WIDTH-1:0] in_valA,
   input  logic [WIDTH-1:0] in_valB,
   input  logic [3:0]       in_dstE,
   input  logic [3:0]       in_dstM,
   input  logic             bubble,
   input  logic             cc_inhibit,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_icode,
   output logic [WIDTH-1:0] out_valE,
   output logic [WIDTH-1:0] out_valA,
   output logic [3:0]       out_dstE,
   output logic [3:0]       out_dstM,
   output logic             out_cnd,
   output logic [1:0]       out_stat,
   output logic             zf,
   output logic             sf,
   output logic             of
);

   localparam logic [3:0] I_HALT  = 4'h0;
   localparam logic [3:0] I_NOP   = 4'h1;
   localparam logic [3:0] I_CMOV  = 4'h2;
   localparam logic [3:0] I_IRMOV = 4'h3;
   localparam logic [3:0] I_RMMOV = 4'h4;
   localparam logic [3:0] I_MRMOV = 4'h5;
   localparam logic [3:0] I_OPQ   = 4'h6;
   localparam logic [3:0] I_JXX   = 4'h7;
   localparam logic [3:0] I_CALL  = 4'h8;
   localparam logic [3:0] I_RET   = 4'h9;
   localparam logic [3:0] I_PUSH  = 4'hA;
   localparam logic [3:0] I_POP   = 4'hB;

   localparam logic [1:0] S_AOK = 2'd0;
   localparam logic [1:0] S_HLT = 2'd1;
   localparam logic [1:0] S_INS = 2'd2;

   localparam logic signed [WIDTH-1:0] STACK_STEP = WIDTH'(8);

   typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR} alu_op_e;

   function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                    input logic signed [WIDTH-1:0] b,
                                    input logic signed [WIDTH-1:0] r);
      return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
   endfunction

   // Minuend is valB; overflow when operand signs differ and the result sign
   // departs from the minuend.
   function automatic logic sub_ovf(input logic signed [WIDTH-1:0] m,
                                    input logic signed [WIDTH-1:0] s,
                                    input logic signed [WIDTH-1:0] r);
      return (m[WIDTH-1] != s[WIDTH-1]) && (r[WIDTH-1] != m[WIDTH-1]);
   endfunction

   function automatic logic cond_eval(input logic [3:0] fn, input logic z,
                                      input logic s, input logic o);
      logic res;
      case (fn)
         4'd0:    res = 1'b1;
         4'd1:    res = (s ^ o) | z;
         4'd2:    res = s ^ o;
         4'd3:    res = z;
         4'd4:    res = !z;
         4'd5:    res = !(s ^ o);
         4'd6:    res = !(s ^ o) & !z;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   logic                    accept;
   logic signed [WIDTH-1:0] alu_a;
   logic signed [WIDTH-1:0] alu_b;
   logic signed [WIDTH-1:0] alu_r;
   alu_op_e                 alu_op;
   logic                    alu_of;
   logic [1:0]              stat_c;
   logic                    cnd_c;
   logic                    opq_ok;
   logic                    cc_ld;
   logic [3:0]              dste_c;

   logic                    vld_p1;
   logic [3:0]              icode_p1;
   logic signed [WIDTH-1:0] vale_p1;
   logic signed [WIDTH-1:0] vala_p1;
   logic [3:0]              dste_p1;
   logic [3:0]              dstm_p1;
   logic                    cnd_p1;
   logic [1:0]              stat_p1;
   logic                    zf_q;
   logic                    sf_q;
   logic                    of_q;

   assign in_ready = !vld_p1 | out_ready;
   assign accept   = in_valid & in_ready;

   // Operand selection and status decode
   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_op = ALU_ADD;
      stat_c = S_AOK;
      opq_ok = 1'b0;
      cnd_c  = 1'b0;
      case (in_icode)
         I_HALT:  stat_c = S_HLT;
         I_NOP:   ;
         I_CMOV: begin
            alu_a = in_valA;
            cnd_c = cond_eval(in_ifun, zf_q, sf_q, of_q);
            if (in_ifun > 4'd6) stat_c = S_INS;
         end
         I_JXX: begin
            cnd_c = cond_eval(in_ifun, zf_q, sf_q, of_q);
            if (in_ifun > 4'd6) stat_c = S_INS;
         end
         I_IRMOV: alu_a = in_valC;
         I_RMMOV, I_MRMOV: begin
            alu_a = in_valC;
            alu_b = in_valB;
         end
         I_OPQ: begin
            if (in_ifun <= 4'd3) begin
               alu_a  = in_valA;
               alu_b  = in_valB;
               alu_op = alu_op_e'(in_ifun[1:0]);
               opq_ok = 1'b1;
            end else begin
               stat_c = S_INS;
            end
         end
         I_CALL, I_PUSH: begin
            alu_a  = STACK_STEP;
            alu_b  = in_valB;
            alu_op = ALU_SUB;
         end
         I_RET, I_POP: begin
            alu_a = STACK_STEP;
            alu_b = in_valB;
         end
         default: stat_c = S_INS;
      endcase
   end

   always_comb begin
      alu_r  = '0;
      alu_of = 1'b0;
      case (alu_op)
         ALU_ADD: begin
            alu_r  = alu_b + alu_a;
            alu_of = add_ovf(alu_a, alu_b, alu_r);
         end
         ALU_SUB: begin
            alu_r  = alu_b - alu_a;
            alu_of = sub_ovf(alu_b, alu_a, alu_r);
         end
         ALU_AND: alu_r = alu_b & alu_a;
         ALU_XOR: alu_r = alu_b ^ alu_a;
         default: alu_r = '0;
      endcase
   end

   assign dste_c = (in_icode == I_CMOV && !cnd_c) ? RNONE : in_dstE;
   assign cc_ld  = accept & opq_ok & !bubble & !cc_inhibit;

   // Stage boundary: output pipeline register and condition codes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         icode_p1 <= I_NOP;
         vale_p1  <= '0;
         vala_p1  <= '0;
         dste_p1  <= RNONE;
         dstm_p1  <= RNONE;
         cnd_p1   <= 1'b0;
         stat_p1  <= S_AOK;
         zf_q     <= 1'b1;
         sf_q     <= 1'b0;
         of_q     <= 1'b0;
      end else begin
         if (accept) begin
            vld_p1 <= 1'b1;
            if (bubble) begin
               icode_p1 <= I_NOP;
               vale_p1  <= '0;
               vala_p1  <= '0;
               dste_p1  <= RNONE;
               dstm_p1  <= RNONE;
               cnd_p1   <= 1'b0;
               stat_p1  <= S_AOK;
            end else begin
               icode_p1 <= in_icode;
               vale_p1  <= alu_r;
               vala_p1  <= in_valA;
               dste_p1  <= dste_c;
               dstm_p1  <= in_dstM;
               cnd_p1   <= cnd_c;
               stat_p1  <= stat_c;
            end
         end else if (out_ready) begin
            vld_p1 <= 1'b0;
         end
         if (cc_ld) begin
            zf_q <= (alu_r == '0);
            sf_q <= alu_r[WIDTH-1];
            of_q <= alu_of;
         end
      end
   end

   assign out_valid = vld_p1;
   assign out_icode = icode_p1;
   assign out_valE  = vale_p1;
   assign out_valA  = vala_p1;
   assign out_dstE  = dste_p1;
   assign out_dstM  = dstm_p1;
   assign out_cnd   = cnd_p1;
   assign out_stat  = stat_p1;
   assign zf        = zf_q;
   assign sf        = sf_q;
   assign of        = of_q;

endmodule

// File: tb/tb_pipe_execute.sv
// Scoreboard bench for pipe_execute: driver pushes reference-model predictions,
// monitor pops and compares whenever the DUT hands an instruction downstream.
`timescale 1ns/1ps
module tb_pipe_execute;
   localparam int         W  = 64;
   localparam logic [3:0] RN = 4'hF;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         in_valid, in_ready, bubble, cc_inhibit, out_valid, out_ready;
   logic [3:0]   in_icode, in_ifun, in_dstE, in_dstM, out_icode, out_dstE, out_dstM;
   logic [W-1:0] in_valC, in_valA, in_valB, out_valE, out_valA;
   logic         out_cnd, zf, sf, of;
   logic [1:0]   out_stat;

   pipe_execute #(.WIDTH(W), .RNONE(RN)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_icode(in_icode), .in_ifun(in_ifun), .in_valC(in_valC), .in_valA(in_valA),
      .in_valB(in_valB), .in_dstE(in_dstE), .in_dstM(in_dstM), .bubble(bubble),
      .cc_inhibit(cc_inhibit), .out_valid(out_valid), .out_ready(out_ready),
      .out_icode(out_icode), .out_valE(out_valE), .out_valA(out_valA),
      .out_dstE(out_dstE), .out_dstM(out_dstM), .out_cnd(out_cnd),
      .out_stat(out_stat), .zf(zf), .sf(sf), .of(of));

   // Narrow instance for the 16-bit wrap case
   logic        u_in_valid, u_in_ready, u_out_valid, u_out_cnd, u_zf, u_sf, u_of;
   logic [3:0]  u_out_icode, u_out_dstE, u_out_dstM;
   logic [15:0] u_valA, u_valB, u_out_valE, u_out_valA;
   logic [1:0]  u_out_stat;

   pipe_execute #(.WIDTH(16), .RNONE(RN)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(u_in_valid), .in_ready(u_in_ready),
      .in_icode(4'h6), .in_ifun(4'h0), .in_valC(16'h0), .in_valA(u_valA),
      .in_valB(u_valB), .in_dstE(4'h1), .in_dstM(RN), .bubble(1'b0),
      .cc_inhibit(1'b0), .out_valid(u_out_valid), .out_ready(1'b1),
      .out_icode(u_out_icode), .out_valE(u_out_valE), .out_valA(u_out_valA),
      .out_dstE(u_out_dstE), .out_dstM(u_out_dstM), .out_cnd(u_out_cnd),
      .out_stat(u_out_stat), .zf(u_zf), .sf(u_sf), .of(u_of));

   typedef struct packed {
      logic [3:0]  icode, ifun;
      logic [63:0] valC, valA, valB;
      logic [3:0]  dstE, dstM;
      logic        bub, inh;
   } instr_t;

   typedef struct packed {
      logic [3:0]  icode;
      logic [63:0] valE, valA;
      logic [3:0]  dstE, dstM;
      logic        cnd;
      logic [1:0]  stat;
      logic        zf, sf, of;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   passed = 0;
   logic mzf = 1'b1, msf = 1'b0, mof = 1'b0;
   logic rdy = 1'b1;

   function automatic void check(string name, logic [159:0] act, logic [159:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endfunction

   function automatic logic cond_ok(logic [3:0] fn);
      case (fn)
         4'd0: return 1'b1;
         4'd1: return (msf != mof) || mzf;
         4'd2: return msf != mof;
         4'd3: return mzf;
         4'd4: return !mzf;
         4'd5: return msf == mof;
         4'd6: return (msf == mof) && !mzf;
         default: return 1'b0;
      endcase
   endfunction

   // Reference model: architectural meaning of each instruction; overflow via
   // a widened signed sum compared against the wrapped result.
   function automatic exp_t predict(instr_t t);
      exp_t               e;
      logic [63:0]        r;
      logic signed [64:0] wide;
      logic               upd, c, nof;
      e = '0; e.icode = t.icode; e.valA = t.valA; e.dstE = t.dstE; e.dstM = t.dstM;
      upd = 1'b0; nof = 1'b0; r = '0; wide = '0;
      c = cond_ok(t.ifun);
      case (t.icode)
         4'h0: e.stat = 2'd1;
         4'h1: ;
         4'h7: begin e.cnd = c; if (t.ifun > 6) e.stat = 2'd2; end
         4'h2: begin
            e.valE = t.valA; e.cnd = c;
            if (t.ifun > 6) e.stat = 2'd2;
            if (!c) e.dstE = RN;
         end
         4'h3: e.valE = t.valC;
         4'h4, 4'h5: e.valE = t.valB + t.valC;
         4'h6: begin
            if (t.ifun <= 3) begin
               case (t.ifun)
                  4'd0: begin r = t.valB + t.valA; wide = $signed({t.valB[63], t.valB}) + $signed({t.valA[63], t.valA}); nof = (wide != $signed({r[63], r})); end
                  4'd1: begin r = t.valB - t.valA; wide = $signed({t.valB[63], t.valB}) - $signed({t.valA[63], t.valA}); nof = (wide != $signed({r[63], r})); end
                  4'd2: r = t.valB & t.valA;
                  default: r = t.valB ^ t.valA;
               endcase
               e.valE = r; upd = 1'b1;
            end else e.stat = 2'd2;
         end
         4'h8, 4'hA: e.valE = t.valB - 64'd8;
         4'h9, 4'hB: e.valE = t.valB + 64'd8;
         default: e.stat = 2'd2;
      endcase
      if (t.bub) begin
         e.icode = 4'h1; e.valE = '0; e.valA = '0; e.dstE = RN; e.dstM = RN;
         e.cnd = 1'b0; e.stat = 2'd0; upd = 1'b0;
      end
      if (upd && !t.inh) begin mzf = (r == 0); msf = r[63]; mof = nof; end
      e.zf = mzf; e.sf = msf; e.of = mof;
      return e;
   endfunction

   function automatic instr_t mk(logic [3:0] ic, logic [3:0] fn, logic [63:0] c,
                                 logic [63:0] a, logic [63:0] b, logic [3:0] de,
                                 logic [3:0] dm, logic bb, logic ih);
      instr_t t;
      t.icode = ic; t.ifun = fn; t.valC = c; t.valA = a; t.valB = b;
      t.dstE = de; t.dstM = dm; t.bub = bb; t.inh = ih;
      return t;
   endfunction

   task automatic drive(input logic v, input instr_t t, output logic acc);
      @(negedge clk);
      #1;
      in_valid = v; in_icode = t.icode; in_ifun = t.ifun; in_valC = t.valC;
      in_valA = t.valA; in_valB = t.valB; in_dstE = t.dstE; in_dstM = t.dstM;
      bubble = t.bub; cc_inhibit = t.inh; out_ready = rdy;
      #2;
      if (rst_n) check("in_ready", in_ready, !out_valid || rdy);
      acc = v && in_ready && rst_n;
      if (acc) q.push_back(predict(t));
   endtask

   task automatic issue(input instr_t t, output int tries);
      logic acc;
      acc = 1'b0; tries = 0;
      while (!acc && tries < 20) begin drive(1'b1, t, acc); tries++; end
      if (!acc) check("issue_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) drive(1'b0, '0, acc);
   endtask

   // Monitor: compare on handoff, and hold-stable while stalled
   initial begin : monitor
      exp_t cur, snap, e;
      logic stall;
      stall = 1'b0; snap = '0;
      forever begin
         @(negedge clk);
         #4;
         cur = {out_icode, out_valE, out_valA, out_dstE, out_dstM, out_cnd, out_stat, zf, sf, of};
         if (!rst_n) stall = 1'b0;
         else begin
            if (stall) check("stall_hold", cur, snap);
            if (out_valid && out_ready) begin
               if (q.size() == 0) check("unexpected_out", 1, 0);
               else begin e = q.pop_front(); check("out", cur, e); end
            end
            stall = out_valid && !out_ready;
            snap  = cur;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stim
      int     n;
      logic   acc;
      instr_t t;
      in_valid = 0; in_icode = 0; in_ifun = 0; in_valC = 0; in_valA = 0; in_valB = 0;
      in_dstE = 0; in_dstM = 0; bubble = 0; cc_inhibit = 0; out_ready = 1;
      u_in_valid = 0; u_valA = 0; u_valB = 0;
      #21;
      check("rst_flags", {zf, sf, of}, 3'b100);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_regs", {out_icode, out_dstE, out_dstM, out_stat}, {4'h1, RN, RN, 2'd0});
      rst_n = 1'b1;

      issue(mk(4'h7, 4'd3, 64'h40, 0, 0, RN, RN, 0, 0), n);                 // je after reset
      issue(mk(4'h6, 4'd0, 0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'd2, RN, 0, 0), n);
      issue(mk(4'h2, 4'd2, 0, 64'h55, 0, 4'd3, RN, 0, 0), n);               // cmovl
      issue(mk(4'h6, 4'd1, 0, 64'd5, 64'd5, 4'd1, RN, 0, 0), n);
      issue(mk(4'h6, 4'd0, 0, 64'd1, 64'd1, 4'd1, RN, 0, 0), n);
      issue(mk(4'h6, 4'd1, 0, 64'd5, 64'd5, 4'd1, RN, 0, 1), n);            // inhibited
      issue(mk(4'hA, 4'd0, 0, 64'h9, 64'h100, 4'd4, RN, 0, 0), n);
      issue(mk(4'hB, 4'd0, 0, 0, 64'hF8, 4'd4, 4'd5, 0, 0), n);
      issue(mk(4'h8, 4'd0, 64'h200, 0, 64'h1000, 4'd4, RN, 0, 0), n);
      issue(mk(4'h9, 4'd0, 0, 0, 64'h0FF8, 4'd4, RN, 0, 0), n);
      issue(mk(4'h3, 4'd0, 64'hDEAD_BEEF, 0, 0, 4'd6, RN, 0, 0), n);
      issue(mk(4'h4, 4'd0, 64'h10, 64'h7, 64'h100, RN, RN, 0, 0), n);
      issue(mk(4'h0, 4'd0, 0, 0, 0, RN, RN, 0, 0), n);
      issue(mk(4'hC, 4'd0, 0, 0, 0, RN, RN, 0, 0), n);
      issue(mk(4'h6, 4'd5, 0, 64'd3, 64'd3, 4'd1, RN, 0, 0), n);
      issue(mk(4'h6, 4'd0, 0, 64'd3, 64'd4, 4'd1, 4'd2, 1, 0), n);          // bubble
      issue(mk(4'h6, 4'd2, 0, 64'hF0F0, 64'h0FF0, 4'd1, RN, 0, 0), n);
      issue(mk(4'h6, 4'd3, 0, 64'h8000_0000_0000_0000, 64'h1, 4'd1, RN, 0, 0), n);
      issue(mk(4'h7, 4'd6, 0, 0, 0, RN, RN, 0, 0), n);
      idle(2);

      rdy = 1'b0;
      issue(mk(4'h6, 4'd1, 0, 64'd9, 64'd2, 4'd3, RN, 0, 0), n);
      t = mk(4'h6, 4'd0, 0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd3, RN, 0, 0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, t, acc);
         check("bp_no_accept", acc, 0);
      end
      rdy = 1'b1;
      issue(t, n);
      check("bp_release_tries", n, 1);
      idle(2);

      for (int i = 0; i < 400; i++) begin
         rdy = ($urandom_range(0, 3) != 0);
         t.icode = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) t.icode = 4'h6;
         t.ifun = 4'($urandom_range(0, 7));
         t.valC = {$urandom, $urandom};
         t.valA = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
         t.valB = ($urandom_range(0, 3) == 0) ? t.valA : {$urandom, $urandom};
         t.dstE = 4'($urandom); t.dstM = 4'($urandom);
         t.bub = ($urandom_range(0, 7) == 0);
         t.inh = ($urandom_range(0, 7) == 0);
         drive($urandom_range(0, 3) != 0, t, acc);
      end
      rdy = 1'b1;
      idle(3);
      n = 0;
      while (q.size() != 0 && n < 50) begin @(negedge clk); n++; end
      check("drain", q.size(), 0);

      @(negedge clk);
      #1;
      u_valA = 16'h0001; u_valB = 16'hFFFF; u_in_valid = 1'b1;
      @(posedge clk);
      #1;
      u_in_valid = 1'b0;
      check("w16_add_wrap", {u_out_valid, u_out_valE, u_zf, u_sf, u_of}, {1'b1, 16'h0, 3'b100});

      rdy = 1'b0;
      issue(mk(4'h6, 4'd1, 0, 64'd1, 64'd0, 4'd3, 4'd4, 0, 0), n);
      drive(1'b1, mk(4'h6, 4'd0, 0, 64'd2, 64'd2, 4'd3, RN, 0, 0), acc);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_stall",
            {out_valid, out_icode, out_valE, out_valA, out_dstE, out_dstM, out_cnd, out_stat, zf, sf, of},
            {1'b0, 4'h1, 64'h0, 64'h0, RN, RN, 1'b0, 2'd0, 3'b100});
      q.delete();
      mzf = 1'b1; msf = 1'b0; mof = 1'b0;
      rdy = 1'b1;
      idle(2);
      rst_n = 1'b1;
      idle(2);
      check("post_rst_idle", out_valid, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
